// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline scheduler.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   localparam stage_ctrl_t CTRL_PASS   = '{en: 1'b1, flush: 1'b0};
   localparam stage_ctrl_t CTRL_BUBBLE = '{en: 1'b1, flush: 1'b1};
   localparam stage_ctrl_t CTRL_HOLD   = '{en: 1'b0, flush: 1'b0};

endpackage

// File: rtl/hazard_ldu_detect.sv
// Load-use hazard compare between the IF/ID consumer and the ID/EX load producer.
module hazard_ldu_detect
   import pipe_pkg::*;
(
   input  logic       ifid_rs1_use_i,
   input  logic       ifid_rs2_use_i,
   input  logic [4:0] ifid_rs1_addr_i,
   input  logic [4:0] ifid_rs2_addr_i,
   input  logic       idex_load_i,
   input  logic [4:0] idex_rd_addr_i,
   output logic       ldu_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = ifid_rs1_use_i && (ifid_rs1_addr_i == idex_rd_addr_i);
   assign rs2_hit = ifid_rs2_use_i && (ifid_rs2_addr_i == idex_rd_addr_i);

   // x0 is hardwired zero, so a load targeting it never produces a dependency.
   assign ldu_o = idex_load_i && (idex_rd_addr_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_sched_ctrl.sv
// Stage-enable/flush scheduler with LSU-wait watchdog for the 5-stage RV32I pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_sched_ctrl
   import pipe_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 5
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ifid_rs1_addr_i,
   input  logic [4:0]  ifid_rs2_addr_i,
   input  logic        ifid_rs1_use_i,
   input  logic        ifid_rs2_use_i,
   input  logic [4:0]  idex_rd_addr_i,
   input  logic        idex_load_i,
   input  logic        exmem_redirect_i,
   input  logic        mem_req_i,
   input  logic        mem_ready_i,
   output logic        pc_en_o,
   output logic        ifid_en_o,
   output logic        idex_en_o,
   output logic        exmem_en_o,
   output logic        memwb_en_o,
   output logic        ifid_flush_o,
   output logic        idex_flush_o,
   output logic        exmem_flush_o,
   output logic        memwb_flush_o,
   output logic [1:0]  state_o,
   output logic        err_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   sched_state_e     state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             ldu;
   logic             wait_hold;

   logic             pc_en_n;
   stage_ctrl_t      ifid_n, idex_n, exmem_n;
   logic             pc_en_c;
   stage_ctrl_t      ifid_c, idex_c, exmem_c, memwb_c;

   hazard_ldu_detect u_ldu (
      .ifid_rs1_use_i  (ifid_rs1_use_i),
      .ifid_rs2_use_i  (ifid_rs2_use_i),
      .ifid_rs1_addr_i (ifid_rs1_addr_i),
      .ifid_rs2_addr_i (ifid_rs2_addr_i),
      .idex_load_i     (idex_load_i),
      .idex_rd_addr_i  (idex_rd_addr_i),
      .ldu_o           (ldu)
   );

   // Redirect / load-use / pass-through resolution, shared by RUN and the wait-release cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      pc_en_n = 1'b1;
      ifid_n  = CTRL_PASS;
      idex_n  = CTRL_PASS;
      exmem_n = CTRL_PASS;
      if (exmem_redirect_i) begin
         ifid_n  = CTRL_BUBBLE;
         idex_n  = CTRL_BUBBLE;
         exmem_n = CTRL_BUBBLE;
      end else if (ldu) begin
         pc_en_n = 1'b0;
         ifid_n  = CTRL_HOLD;
         idex_n  = CTRL_BUBBLE;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      wait_hold  = 1'b0;
      pc_en_c    = pc_en_n;
      ifid_c     = ifid_n;
      idex_c     = idex_n;
      exmem_c    = exmem_n;
      memwb_c    = CTRL_PASS;
      unique case (state_q)
         ST_RUN: begin
            if (mem_req_i && !mem_ready_i) begin
               wait_hold  = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = CNT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_ready_i) begin
               wait_hold = 1'b1;
               if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) state_d = ST_ERR;
               else                                    wait_cnt_d = wait_cnt_q + 1'b1;
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         ST_ERR: begin
            pc_en_c = 1'b0;
            ifid_c  = CTRL_HOLD;
            idex_c  = CTRL_HOLD;
            exmem_c = CTRL_HOLD;
            memwb_c = CTRL_HOLD;
         end
         default: state_d = ST_RUN;
      endcase
      // LSU wait freezes everything older than MEM/WB and drains a bubble into writeback.
      if (wait_hold) begin
         pc_en_c = 1'b0;
         ifid_c  = CTRL_HOLD;
         idex_c  = CTRL_HOLD;
         exmem_c = CTRL_HOLD;
         memwb_c = CTRL_BUBBLE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst_i) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign pc_en_o       = pc_en_c       & ~rst_i;
   assign ifid_en_o     = ifid_c.en     & ~rst_i;
   assign idex_en_o     = idex_c.en     & ~rst_i;
   assign exmem_en_o    = exmem_c.en    & ~rst_i;
   assign memwb_en_o    = memwb_c.en    & ~rst_i;
   assign ifid_flush_o  = ifid_c.flush  & ~rst_i;
   assign idex_flush_o  = idex_c.flush  & ~rst_i;
   assign exmem_flush_o = exmem_c.flush & ~rst_i;
   assign memwb_flush_o = memwb_c.flush & ~rst_i;
   assign state_o       = state_q;
   assign err_o         = (state_q == ST_ERR);

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // EX/MEM flush is raised only by a redirect, so it marks each redirect cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_en_c && state_q != ST_ERR) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (exmem_c.flush)                 flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_sched_ctrl.sv
// Directed self-checking bench for pipe_sched_ctrl (MAX_WAIT=4 to exercise the watchdog).
module tb_pipe_sched_ctrl;
   import pipe_pkg::*;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  ifid_rs1_addr_i, ifid_rs2_addr_i, idex_rd_addr_i;
   logic        ifid_rs1_use_i, ifid_rs2_use_i, idex_load_i;
   logic        exmem_redirect_i, mem_req_i, mem_ready_i;
   logic        pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
   logic        ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
   logic [1:0]  state_o;
   logic        err_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;

   int vectors    = 0;
   int miscompares = 0;

   // {pc, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
   logic [8:0] ctrl;
   assign ctrl = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
                  ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o};

   localparam logic [8:0] C_ZERO  = 9'b0_0000_0000;
   localparam logic [8:0] C_RUN   = 9'b1_1111_0000;
   localparam logic [8:0] C_LDU   = 9'b0_0111_0100;
   localparam logic [8:0] C_REDIR = 9'b1_1111_1110;
   localparam logic [8:0] C_WAIT  = 9'b0_0001_0001;

   always #5 clk_i = ~clk_i;

   pipe_sched_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ifid_rs1_addr_i  (ifid_rs1_addr_i),
      .ifid_rs2_addr_i  (ifid_rs2_addr_i),
      .ifid_rs1_use_i   (ifid_rs1_use_i),
      .ifid_rs2_use_i   (ifid_rs2_use_i),
      .idex_rd_addr_i   (idex_rd_addr_i),
      .idex_load_i      (idex_load_i),
      .exmem_redirect_i (exmem_redirect_i),
      .mem_req_i        (mem_req_i),
      .mem_ready_i      (mem_ready_i),
      .pc_en_o          (pc_en_o),
      .ifid_en_o        (ifid_en_o),
      .idex_en_o        (idex_en_o),
      .exmem_en_o       (exmem_en_o),
      .memwb_en_o       (memwb_en_o),
      .ifid_flush_o     (ifid_flush_o),
      .idex_flush_o     (idex_flush_o),
      .exmem_flush_o    (exmem_flush_o),
      .memwb_flush_o    (memwb_flush_o),
      .state_o          (state_o),
      .err_o            (err_o),
      .stall_cnt_o      (stall_cnt_o),
      .flush_cnt_o      (flush_cnt_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [8:0] c, input logic [1:0] st, input logic er);
      check({tag, ".ctrl"},  {23'd0, ctrl}, {23'd0, c});
      check({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
      check({tag, ".err"},   {31'd0, err_o}, {31'd0, er});
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      ifid_rs1_addr_i = 5'd0; ifid_rs2_addr_i = 5'd0;
      ifid_rs1_use_i = 1'b0;  ifid_rs2_use_i = 1'b0;
      idex_rd_addr_i = 5'd0;  idex_load_i = 1'b0;
      exmem_redirect_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
   endtask

   task automatic set_ldu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
      idex_load_i = 1'b1; idex_rd_addr_i = rd;
      ifid_rs1_addr_i = rs1; ifid_rs1_use_i = u1;
      ifid_rs2_addr_i = rs2; ifid_rs2_use_i = u2;
   endtask

   initial begin
      idle();
      rst_i = 1'b1;
      #1;
      check_all("reset0", C_ZERO, 2'd0, 1'b0);
      tick(); tick(); tick();
      check_all("reset3", C_ZERO, 2'd0, 1'b0);
      check("reset.stall_cnt", stall_cnt_o, 32'd0);
      check("reset.flush_cnt", flush_cnt_o, 32'd0);
      rst_i = 1'b0; #1;
      check_all("release", C_RUN, 2'd0, 1'b0);

      // Load-use through rs2, one bubble then free-running.
      set_ldu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); #1;
      check_all("ldu_rs2", C_LDU, 2'd0, 1'b0);
      tick(); idle(); #1;
      check_all("ldu_after", C_RUN, 2'd0, 1'b0);
      // Back-to-back pair through rs1: exactly one more bubble.
      set_ldu(5'd7, 5'd7, 1'b1, 5'd3, 1'b1); #1;
      check_all("ldu_rs1", C_LDU, 2'd0, 1'b0);
      tick(); idle(); #1;
      check_all("ldu_rs1_after", C_RUN, 2'd0, 1'b0);
      set_ldu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); #1;
      check_all("ldu_x0", C_RUN, 2'd0, 1'b0);
      set_ldu(5'd9, 5'd9, 1'b0, 5'd9, 1'b0); #1;
      check_all("ldu_nouse", C_RUN, 2'd0, 1'b0);
      set_ldu(5'd9, 5'd8, 1'b1, 5'd10, 1'b1); idex_load_i = 1'b0; #1;
      check_all("ldu_noload", C_RUN, 2'd0, 1'b0);
      tick(); idle();

      // Redirect.
      exmem_redirect_i = 1'b1; #1;
      check_all("redirect", C_REDIR, 2'd0, 1'b0);
      tick(); idle(); #1;
      check_all("redirect_after", C_RUN, 2'd0, 1'b0);
      check("redirect.flush_cnt", flush_cnt_o, PERF ? 32'd1 : 32'd0);
      check("redirect.stall_cnt", stall_cnt_o, PERF ? 32'd2 : 32'd0);

      // Redirect beats load-use.
      set_ldu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); exmem_redirect_i = 1'b1; #1;
      check_all("prio_redir_ldu", C_REDIR, 2'd0, 1'b0);
      tick(); idle(); #1;
      check("prio.flush_cnt", flush_cnt_o, PERF ? 32'd2 : 32'd0);

      // LSU wait: 3 not-ready cycles, then release. Redirect alongside loses to the wait.
      mem_req_i = 1'b1; mem_ready_i = 1'b0; exmem_redirect_i = 1'b1; #1;
      check_all("wait1", C_WAIT, 2'd0, 1'b0);
      tick(); exmem_redirect_i = 1'b0;
      set_ldu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0); #1;
      check_all("wait2_ldu", C_WAIT, 2'd1, 1'b0);
      tick(); idex_load_i = 1'b0; #1;
      check_all("wait3", C_WAIT, 2'd1, 1'b0);
      tick(); mem_ready_i = 1'b1; #1;
      check_all("wait_release", C_RUN, 2'd1, 1'b0);
      tick(); idle(); #1;
      check_all("wait_done", C_RUN, 2'd0, 1'b0);
      check("wait.stall_cnt", stall_cnt_o, PERF ? 32'd5 : 32'd0);
      check("wait.flush_cnt", flush_cnt_o, PERF ? 32'd2 : 32'd0);

      // Release cycle resolves a pending load-use.
      mem_req_i = 1'b1; mem_ready_i = 1'b0; #1;
      check_all("wait_b1", C_WAIT, 2'd0, 1'b0);
      tick(); mem_ready_i = 1'b1; set_ldu(5'd2, 5'd0, 1'b0, 5'd2, 1'b1); #1;
      check_all("release_ldu", C_LDU, 2'd1, 1'b0);
      tick(); idle(); #1;
      check_all("release_ldu_after", C_RUN, 2'd0, 1'b0);
      check("release.stall_cnt", stall_cnt_o, PERF ? 32'd7 : 32'd0);

      // Watchdog: ERR after 4 wait cycles.
      mem_req_i = 1'b1; mem_ready_i = 1'b0; #1;
      check_all("wd1", C_WAIT, 2'd0, 1'b0);
      tick(); check_all("wd2", C_WAIT, 2'd1, 1'b0);
      tick(); check_all("wd3", C_WAIT, 2'd1, 1'b0);
      tick(); check_all("wd4", C_WAIT, 2'd1, 1'b0);
      tick(); check_all("wd_err", C_ZERO, 2'd2, 1'b1);
      mem_ready_i = 1'b1; exmem_redirect_i = 1'b1;
      tick(); tick(); #1;
      check_all("err_sticky", C_ZERO, 2'd2, 1'b1);
      check("err.stall_cnt", stall_cnt_o, PERF ? 32'd11 : 32'd0);
      check("err.flush_cnt", flush_cnt_o, PERF ? 32'd2 : 32'd0);
      idle();
      rst_i = 1'b1; #1;
      check_all("err_rst", C_ZERO, 2'd0, 1'b0);
      check("err_rst.stall_cnt", stall_cnt_o, 32'd0);
      tick(); rst_i = 1'b0; #1;
      check_all("err_rst_release", C_RUN, 2'd0, 1'b0);

      // Reset mid-MEM_WAIT returns straight to RUN with a cleared wait counter.
      mem_req_i = 1'b1; mem_ready_i = 1'b0;
      tick(); tick(); #1;
      check_all("midwait", C_WAIT, 2'd1, 1'b0);
      rst_i = 1'b1; #1;
      check_all("midwait_rst", C_ZERO, 2'd0, 1'b0);
      tick(); rst_i = 1'b0; #1;
      check_all("midwait_rst_run", C_WAIT, 2'd0, 1'b0);
      tick(); tick(); tick(); #1;
      check_all("midwait_cnt_cleared", C_WAIT, 2'd1, 1'b0);
      tick(); #1;
      check_all("midwait_err", C_ZERO, 2'd2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
